ahb_slave_arbiter_n: RTL and testbench
======================================

AHB_SLAVE_ARBITER_N -- requirements
Module: ahb_slave_arbiter_n

Interface
REQ-001 SHALL have parameter MASTER_NUM, default 2: number of requesting masters, legal range 1..16.
REQ-002 SHALL have parameter ARB_MODE, default ARB_FIXED: arbitration mode, ARB_FIXED or ARB_RR.
REQ-003 SHALL have parameter MAX_INCR_BEATS, default 16: beat cap for undefined-length INCR bursts, legal range 2..256.
REQ-004 SHALL have port hclk, input, 1: clock; all state changes on its rising edge.
REQ-005 SHALL have port hreset_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port hreq, input, MASTER_NUM: per-master bus request.
REQ-007 SHALL have port hburst, input, MASTER_NUM x hburst_type: per-master burst type.
REQ-008 SHALL have port hready, input, 1: slave ready; high completes the current beat.
REQ-009 SHALL have port hgrant, output, MASTER_NUM: registered one-hot grant, or all zero.
REQ-010 SHALL have port hmaster, output, max(1,$clog2(MASTER_NUM)): index of the granted master; 0 when none.
REQ-011 SHALL have port hsel, output, 1: equals OR of hgrant.
REQ-012 SHALL have port hlast, output, 1: high during the final beat of the current grant.

Function
REQ-013 SHALL arbitrate only in state IDLE, or in state BURST on a cycle where hlast and hready are both high; the result registers into hgrant on the next edge (1-cycle latency).
REQ-014 SHALL, for ARB_FIXED, grant the lowest-index requesting master.
REQ-015 SHALL, for ARB_RR, search upward starting at last-granted index + 1, modulo MASTER_NUM; the pointer resets to MASTER_NUM-1 so that master 0 wins first.
REQ-016 SHALL register the granted master's hburst at grant time.
- Beat limit: 1 for SINGLE, 4 for INCR4/WRAP4, 8 for INCR8/WRAP8, 16 for INCR16/WRAP16.
REQ-017 SHALL, for INCR, hold the grant until either the granted master's hreq is low at hready, or MAX_INCR_BEATS beats have completed, whichever comes first.
REQ-018 SHALL implement the beat counter with $clog2(MAX_INCR_BEATS)+1 bits.
- Clears on a new grant.
- Increments only when hready is high and hsel is high.
- Never wraps past the limit.
REQ-019 SHALL assert hlast when count equals limit-1, or, for INCR, when hreq of the owner is low.
REQ-020 SHALL implement a state machine with two states:
- IDLE: hgrant is zero; moves to BURST when any hreq is high.
- BURST: on hlast & hready, moves to BURST with a new winner if any hreq is high, else to IDLE.
REQ-021 SHALL complete a fixed-length burst after the owner drops hreq; the grant is not removed early.
REQ-022 SHALL keep count, state and grant frozen while hready is low, including on the last beat.
REQ-023 SHALL allow the current owner to win re-arbitration when requests are simultaneous, subject to REQ-014 or REQ-015.

Reset
REQ-024 SHALL, while hreset_n is low, force the following regardless of the clock:
- hgrant=0, hmaster=0, hsel=0, hlast=0
- state IDLE, count 0, RR pointer MASTER_NUM-1
REQ-025 SHALL abandon any in-progress burst on reset assertion; the first grant after release follows REQ-013.

Configuration
REQ-026 SHALL support macro AHB_ARB_HLOCK_EN.
- When defined: adds input port hlock, MASTER_NUM bits. While the owner's hlock is high at hlast & hready, the grant stays with the owner, the counter restarts, and other requests are ignored.
- When undefined: port hlock is absent and no lock logic is built.

Structure
REQ-027 SHALL use hburst_type from AHB_package; arb_mode_e (ARB_FIXED=0, ARB_RR=1) SHALL be added to AHB_package.
REQ-028 SHALL place the winner selection in one combinational sub-module, ahb_arb_pick.
- Inputs: requests, pointer, mode.
- Output: one-hot winner.

Verification
REQ-029 SHALL cover: MASTER_NUM=4, ARB_FIXED; hreq=4'b1010 -> hgrant=4'b0010 one cycle later, hmaster=1.
REQ-030 SHALL cover: ARB_RR, MASTER_NUM=4, all hreq high, SINGLE bursts -> grant order 0,1,2,3,0, one per hready beat.
REQ-031 SHALL cover: INCR8 grant with hready low on beats 3 and 6 -> grant held for 8 ready beats, hlast high only on beat 8.
REQ-032 SHALL cover: INCR, MAX_INCR_BEATS=4, owner holds hreq -> forced hlast on beat 4, re-arbitration to the other requester.
REQ-033 SHALL cover: with AHB_ARB_HLOCK_EN, master 1 hlock high across two INCR4 bursts while master 0 requests -> master 0 granted only after hlock drops.
REQ-034 SHALL cover: hreset_n pulsed low mid-INCR16 -> all outputs 0 immediately, IDLE, fresh arbitration after release.

Source files
------------

// File: rtl/ahb_slave_arbiter_n_pkg.sv
// ahb_slave_arbiter_n_pkg: AHB burst encoding, arbitration modes, arbiter states and beat-limit helper
package AHB_package;
  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_type;
  typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_e;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} arb_state_e;
  // Number of beats a grant lasts for the given burst type; INCR uses the configured cap.
  function automatic int beat_limit(input hburst_type b, input int incr_max);
    return b == SINGLE ? 1 :
           b == INCR ? incr_max :
           (b == WRAP4 || b == INCR4) ? 4 :
           (b == WRAP8 || b == INCR8) ? 8 : 16;
  endfunction
endpackage

// File: rtl/ahb_slave_arbiter_n_pick.sv
// ahb_arb_pick: combinational one-hot winner select, lowest index or round-robin after the pointer
module ahb_arb_pick
  import AHB_package::*;
#(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  arb_mode_e     mode_i,
  output logic [N-1:0]  gnt_o
);
  logic [PW-1:0] idx;
  logic found;
  // Scan N slots from the mode's start point; the first requester seen wins.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = mode_i == ARB_RR ? PW'((int'(ptr_i) + 1 + k) % N) : PW'(k);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ahb_slave_arbiter_n.sv
// ahb_slave_arbiter_n: N-master AHB slave-side arbiter with burst-length tracking.
// Define AHB_ARB_HLOCK_EN to add the hlock port, which keeps the grant with a locked owner.
module ahb_slave_arbiter_n
  import AHB_package::*;
#(
  parameter int        MASTER_NUM     = 2,
  parameter arb_mode_e ARB_MODE       = ARB_FIXED,
  parameter int        MAX_INCR_BEATS = 16,
  localparam int       MW             = MASTER_NUM > 1 ? $clog2(MASTER_NUM) : 1
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  input  logic [MASTER_NUM-1:0] hreq,
  input  hburst_type            hburst [MASTER_NUM],
  input  logic                  hready,
  output logic [MASTER_NUM-1:0] hgrant,
  output logic [MW-1:0]         hmaster,
  output logic                  hsel,
  output logic                  hlast
`ifdef AHB_ARB_HLOCK_EN
  ,
  input  logic [MASTER_NUM-1:0] hlock
`endif
);
  // Counter is wide enough for the INCR cap and for the 16-beat fixed bursts.
  localparam int CW = $clog2(MAX_INCR_BEATS) + 1 > 5 ? $clog2(MAX_INCR_BEATS) + 1 : 5;
  arb_state_e state_q, state_d;
  logic [MASTER_NUM-1:0] grant_q, grant_d, win;
  logic [MW-1:0] master_q, master_d, ptr_q, ptr_d, win_idx;
  hburst_type burst_q, burst_d;
  logic [CW-1:0] count_q, count_d, last_cnt;
  logic lock;
`ifdef AHB_ARB_HLOCK_EN
  assign lock = hlock[master_q];
`else
  assign lock = 1'b0;
`endif
  assign last_cnt = CW'(beat_limit(burst_q, MAX_INCR_BEATS) - 1);
  assign hlast    = state_q == BURST && (count_q == last_cnt || (burst_q == INCR && !hreq[master_q]));
  assign hgrant   = grant_q;
  assign hmaster  = master_q;
  assign hsel     = |grant_q;
  ahb_arb_pick #(.N(MASTER_NUM), .PW(MW)) u_pick (
    .req_i (hreq),
    .ptr_i (ptr_q),
    .mode_i(ARB_MODE),
    .gnt_o (win)
  );
  // One-hot winner to index.
  always_comb begin
    win_idx = '0;
    for (int k = 0; k < MASTER_NUM; k++) if (win[k]) win_idx = MW'(k);
  end
  // Next state: hold on stall, count mid-burst, relock or re-arbitrate at the last ready beat.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    master_d = master_q;
    ptr_d    = ptr_q;
    burst_d  = burst_q;
    count_d  = count_q;
    if (state_q == BURST && !hready) begin
      count_d = count_q;
    end else if (state_q == BURST && !hlast) begin
      count_d = count_q + 1'b1;
    end else if (state_q == BURST && lock) begin
      count_d = '0;
      burst_d = hburst[master_q];
    end else if (|hreq) begin
      state_d  = BURST;
      grant_d  = win;
      master_d = win_idx;
      ptr_d    = win_idx;
      burst_d  = hburst[win_idx];
      count_d  = '0;
    end else begin
      state_d  = IDLE;
      grant_d  = '0;
      master_d = '0;
      count_d  = '0;
    end
  end
  // State register; reset abandons any burst and aims the pointer so master 0 wins first.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      master_q <= '0;
      ptr_q    <= MW'(MASTER_NUM - 1);
      burst_q  <= SINGLE;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      master_q <= master_d;
      ptr_q    <= ptr_d;
      burst_q  <= burst_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_ahb_slave_arbiter_n.sv
// tb_ahb_slave_arbiter_n: directed checks of a fixed-priority and a round-robin arbiter instance
module tb_ahb_slave_arbiter_n;
  import AHB_package::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req_a = '0, req_b = '0;
  hburst_type bur_a [4];
  hburst_type bur_b [4];
  logic rdy_a = 1'b1, rdy_b = 1'b1;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] mst_a, mst_b;
  logic sel_a, sel_b, last_a, last_b;
  logic [10:0] rdy_pat = 11'b10110111011;
`ifdef AHB_ARB_HLOCK_EN
  logic [3:0] lock_a = '0, lock_b = '0;
`endif
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  ahb_slave_arbiter_n #(.MASTER_NUM(4), .ARB_MODE(ARB_FIXED), .MAX_INCR_BEATS(16)) u_a (
    .hclk(clk), .hreset_n(rst_n), .hreq(req_a), .hburst(bur_a), .hready(rdy_a),
    .hgrant(gnt_a), .hmaster(mst_a), .hsel(sel_a), .hlast(last_a)
`ifdef AHB_ARB_HLOCK_EN
    , .hlock(lock_a)
`endif
  );
  ahb_slave_arbiter_n #(.MASTER_NUM(4), .ARB_MODE(ARB_RR), .MAX_INCR_BEATS(4)) u_b (
    .hclk(clk), .hreset_n(rst_n), .hreq(req_b), .hburst(bur_b), .hready(rdy_b),
    .hgrant(gnt_b), .hmaster(mst_b), .hsel(sel_b), .hlast(last_b)
`ifdef AHB_ARB_HLOCK_EN
    , .hlock(lock_b)
`endif
  );
  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask
  task automatic exp_a(input string tag, input logic [3:0] g, input int m, input logic l);
    #1;
    check({tag, " gnt"}, int'(gnt_a), int'(g));
    check({tag, " mst"}, int'(mst_a), m);
    check({tag, " sel"}, int'(sel_a), int'(|g));
    check({tag, " last"}, int'(last_a), int'(l));
  endtask
  task automatic exp_b(input string tag, input logic [3:0] g, input int m, input logic l);
    #1;
    check({tag, " gnt"}, int'(gnt_b), int'(g));
    check({tag, " mst"}, int'(mst_b), m);
    check({tag, " sel"}, int'(sel_b), int'(|g));
    check({tag, " last"}, int'(last_b), int'(l));
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin
      bur_a[i] = SINGLE;
      bur_b[i] = SINGLE;
    end
    #2;
    exp_a("rst a", 4'b0000, 0, 1'b0);
    exp_b("rst b", 4'b0000, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req_a = 4'b1010;
    exp_a("fix lat", 4'b0000, 0, 1'b0);
    @(negedge clk);
    exp_a("fix win", 4'b0010, 1, 1'b1);
    req_a = 4'b1100;
    @(negedge clk);
    exp_a("fix next", 4'b0100, 2, 1'b1);
    req_a = 4'b0000;
    @(negedge clk);
    exp_a("fix idle", 4'b0000, 0, 1'b0);
    bur_a[2] = INCR8;
    req_a = 4'b0100;
    @(negedge clk);
    req_a = 4'b0000;
    for (int c = 0; c < 11; c++) begin
      rdy_a = rdy_pat[c];
      exp_a($sformatf("incr8 c%0d", c), 4'b0100, 2, c >= 9);
      @(negedge clk);
    end
    rdy_a = 1'b1;
    exp_a("incr8 end", 4'b0000, 0, 1'b0);
    req_b = 4'b1111;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      exp_b($sformatf("rr k%0d", k), 4'(1 << (k % 4)), k % 4, 1'b1);
      if (k == 4) req_b = 4'b0000;
      @(negedge clk);
    end
    exp_b("rr idle", 4'b0000, 0, 1'b0);
    bur_b[1] = INCR;
    req_b = 4'b0110;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      exp_b($sformatf("cap k%0d", k), 4'b0010, 1, k == 3);
      @(negedge clk);
    end
    exp_b("cap next", 4'b0100, 2, 1'b1);
    req_b = 4'b0000;
    @(negedge clk);
    exp_b("cap idle", 4'b0000, 0, 1'b0);
    req_b = 4'b0010;
    @(negedge clk);
    exp_b("incr own", 4'b0010, 1, 1'b0);
    req_b = 4'b0000;
    exp_b("incr drop", 4'b0010, 1, 1'b1);
    @(negedge clk);
    exp_b("incr idle", 4'b0000, 0, 1'b0);
`ifdef AHB_ARB_HLOCK_EN
    bur_a[1] = INCR4;
    bur_a[0] = SINGLE;
    lock_a = 4'b0010;
    req_a = 4'b0010;
    @(negedge clk);
    req_a = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) lock_a = 4'b0000;
      exp_a($sformatf("lock k%0d", k), 4'b0010, 1, (k % 4) == 3);
      @(negedge clk);
    end
    exp_a("lock m0", 4'b0001, 0, 1'b1);
    req_a = 4'b0000;
    @(negedge clk);
    exp_a("lock idle", 4'b0000, 0, 1'b0);
`endif
    bur_a[0] = INCR16;
    req_a = 4'b0001;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      exp_a($sformatf("i16 k%0d", k), 4'b0001, 0, 1'b0);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    exp_a("rst async", 4'b0000, 0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_a("rst lat", 4'b0000, 0, 1'b0);
    @(negedge clk);
    exp_a("rst regrant", 4'b0001, 0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
